// File: rtl/lfsr_range_rng_if.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_range_rng_if
//  Purpose  : Seed / request / response bundle for lfsr_range_rng.
//             The master is the consumer of random values. The slave is the
//             generator.
//  Revision : 1.0  initial release
// ============================================================================
interface lfsr_range_rng_if #(
   parameter int WIDTH = 16,
   parameter int OUT_W = 3
);
   logic             seed_load;
   logic [WIDTH-1:0] seed_in;
   logic             rand_req;
   logic             rand_ready;
   logic             rand_valid;
   logic [OUT_W-1:0] rand_num;
   logic             fallback;
   logic [WIDTH-1:0] lfsr_state;

   modport master (
      output seed_load, seed_in, rand_req, rand_ready,
      input  rand_valid, rand_num, fallback, lfsr_state
   );

   modport slave (
      input  seed_load, seed_in, rand_req, rand_ready,
      output rand_valid, rand_num, fallback, lfsr_state
   );
endinterface
`default_nettype wire

// File: rtl/lfsr_range_rng.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_range_rng
//  Purpose  : Free-running Fibonacci LFSR with a request/ready front end.
//             The front end returns unbiased values 1..RANGE_MAX by rejection
//             sampling. After MAX_TRIES rejected draws it falls back to a
//             modulo reduction.
//  Revision : 1.0  initial release
// ============================================================================
module lfsr_range_rng #(
   parameter int               WIDTH     = 16,
   parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
   parameter logic [WIDTH-1:0] SEED      = 16'h0001,
   parameter int               RANGE_MAX = 4,
   parameter int               MAX_TRIES = 8
) (
   input  wire logic       clk,
   input  wire logic       reset,
   lfsr_range_rng_if.slave bus
);
   localparam int               K          = $clog2(RANGE_MAX);
   localparam int               OUT_W      = $clog2(RANGE_MAX + 1);
   localparam int               TRY_W      = $clog2(MAX_TRIES + 1);
   // A zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [WIDTH-1:0] c_SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;
   localparam logic [K:0]       c_RANGE    = (K + 1)'(RANGE_MAX);
   localparam logic [TRY_W-1:0] c_LAST_TRY = TRY_W'(MAX_TRIES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRAW = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] lfsr_q, lfsr_d;
   logic [TRY_W-1:0] tries_q, tries_d;
   logic             valid_q, valid_d;
   logic [OUT_W-1:0] num_q, num_d;
   logic             fb_q, fb_d;

   logic             w_fb;
   logic [K-1:0]     w_cand;
   logic             w_accept;
   logic [31:0]      w_mod;

   // The candidate comes from the current (pre-step) LFSR state.
   assign w_cand   = lfsr_q[K-1:0];
   assign w_accept = ({1'b0, w_cand} < c_RANGE);
   assign w_mod    = 32'(w_cand) % 32'(RANGE_MAX);

   // LFSR next state. Seed load wins over lock-up recovery, which wins over a normal step.
   always_comb begin
      w_fb   = ^(lfsr_q & TAPS);
      lfsr_d = {lfsr_q[WIDTH-2:0], w_fb};
      if (bus.seed_load) begin
         lfsr_d = (bus.seed_in == '0) ? c_SEED_EFF : bus.seed_in;
      end else if (lfsr_q == '0) begin
         lfsr_d = c_SEED_EFF;
      end
   end

   // Request FSM: accept a request, draw until a candidate fits, then hold until ready.
   always_comb begin
      state_d = state_q;
      tries_d = tries_q;
      valid_d = valid_q;
      num_d   = num_q;
      fb_d    = fb_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.rand_req) begin
               state_d = ST_DRAW;
               tries_d = '0;
            end
         end
         ST_DRAW: begin
            // rand_req is not looked at here: once a draw starts, it always completes.
            if (w_accept) begin
               num_d   = OUT_W'(w_cand) + OUT_W'(1);
               fb_d    = 1'b0;
               valid_d = 1'b1;
               state_d = ST_HOLD;
            end else if (tries_q == c_LAST_TRY) begin
               num_d   = OUT_W'(w_mod) + OUT_W'(1);
               fb_d    = 1'b1;
               valid_d = 1'b1;
               state_d = ST_HOLD;
            end else begin
               tries_d = tries_q + TRY_W'(1);
            end
         end
         ST_HOLD: begin
            if (bus.rand_ready) begin
               valid_d = 1'b0;
               if (bus.rand_req) begin
                  state_d = ST_DRAW;
                  tries_d = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   // State registers. Reset drops any pending value and restarts the LFSR from the seed.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         lfsr_q  <= c_SEED_EFF;
         tries_q <= '0;
         valid_q <= 1'b0;
         num_q   <= '0;
         fb_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         tries_q <= tries_d;
         valid_q <= valid_d;
         num_q   <= num_d;
         fb_q    <= fb_d;
      end
   end

   assign bus.rand_valid = valid_q;
   assign bus.rand_num   = num_q;
   assign bus.fallback   = fb_q;
   assign bus.lfsr_state = lfsr_q;
endmodule
`default_nettype wire

// File: tb/tb_lfsr_range_rng.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lfsr_range_rng
//  Purpose  : Self-checking bench for lfsr_range_rng.
//             Four instances are used: a 4-bit LFSR, the defaults,
//             range 5 with a single try, and range 3 with two tries.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lfsr_range_rng;
   localparam int NI = 3;   // 0: defaults, 1: range 5 / 1 try, 2: range 3 / 2 tries

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   lfsr_range_rng_if #(.WIDTH(4),  .OUT_W(3)) if4 ();
   lfsr_range_rng_if #(.WIDTH(16), .OUT_W(3)) ifd ();
   lfsr_range_rng_if #(.WIDTH(16), .OUT_W(3)) if5 ();
   lfsr_range_rng_if #(.WIDTH(16), .OUT_W(2)) if3 ();

   lfsr_range_rng #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .RANGE_MAX(4), .MAX_TRIES(8))
      u4 (.clk(clk), .reset(reset), .bus(if4));
   lfsr_range_rng ud (.clk(clk), .reset(reset), .bus(ifd));
   lfsr_range_rng #(.RANGE_MAX(5), .MAX_TRIES(1)) u5 (.clk(clk), .reset(reset), .bus(if5));
   lfsr_range_rng #(.RANGE_MAX(3), .MAX_TRIES(2)) u3 (.clk(clk), .reset(reset), .bus(if3));

   int checks = 0;
   int errors = 0;

   int unsigned cfg_range [NI] = '{4, 5, 3};
   int          cfg_tries [NI] = '{8, 1, 2};

   bit          in_load [NI];
   int unsigned in_seed [NI];
   bit          in_req  [NI];
   bit          in_rdy  [NI];
   bit          o_valid [NI];
   bit          o_fb    [NI];
   int unsigned o_num   [NI];
   int unsigned o_lfsr  [NI];

   // reference model state (transaction view of the generator)
   int unsigned m_lfsr  [NI];
   bit          m_draw  [NI];
   bit          m_hold  [NI];
   bit          m_valid [NI];
   bit          m_fb    [NI];
   int          m_tries [NI];
   int unsigned m_num   [NI];

   typedef struct {
      bit          load;
      int unsigned sin;
      bit          req;
      bit          rdy;
      bit          valid;
      int unsigned num;
      bit          fb;
      int unsigned lfsr;
   } vec_t;
   vec_t vt [12];

   int unsigned vals [2][8];
   int          cnt  [5];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic int kbits(input int unsigned rm);
      int k = 0;
      while ((32'd1 << k) < rm) k++;
      return k;
   endfunction

   function automatic int unsigned lstep(input int unsigned s, input int unsigned taps,
                                         input int w, input int unsigned seed);
      int unsigned fb;
      if (s == 0) return seed;
      fb = 32'($countones(s & taps)) & 32'd1;
      return ((s << 1) | fb) & ((32'd1 << w) - 32'd1);
   endfunction

   task automatic drive_bus();
      ifd.seed_load = in_load[0]; ifd.seed_in = 16'(in_seed[0]);
      ifd.rand_req  = in_req[0];  ifd.rand_ready = in_rdy[0];
      if5.seed_load = in_load[1]; if5.seed_in = 16'(in_seed[1]);
      if5.rand_req  = in_req[1];  if5.rand_ready = in_rdy[1];
      if3.seed_load = in_load[2]; if3.seed_in = 16'(in_seed[2]);
      if3.rand_req  = in_req[2];  if3.rand_ready = in_rdy[2];
   endtask

   task automatic sample_bus();
      o_valid[0] = ifd.rand_valid; o_fb[0] = ifd.fallback;
      o_num[0] = 32'(ifd.rand_num); o_lfsr[0] = 32'(ifd.lfsr_state);
      o_valid[1] = if5.rand_valid; o_fb[1] = if5.fallback;
      o_num[1] = 32'(if5.rand_num); o_lfsr[1] = 32'(if5.lfsr_state);
      o_valid[2] = if3.rand_valid; o_fb[2] = if3.fallback;
      o_num[2] = 32'(if3.rand_num); o_lfsr[2] = 32'(if3.lfsr_state);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      sample_bus();
   endtask

   task automatic clear_inputs();
      for (int i = 0; i < NI; i++) begin
         in_load[i] = 1'b0; in_seed[i] = 0; in_req[i] = 1'b0; in_rdy[i] = 1'b0;
      end
      drive_bus();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_valid(input int i, input int maxc, output int n);
      n = 0;
      while (!o_valid[i] && n < maxc) begin
         tick();
         n++;
      end
      if (!o_valid[i]) check("valid_timeout", 0, 1);
   endtask

   task automatic model_reset(input int i);
      m_lfsr[i] = 1; m_draw[i] = 0; m_hold[i] = 0; m_valid[i] = 0;
      m_fb[i] = 0; m_tries[i] = 0; m_num[i] = 0;
   endtask

   task automatic model_step(input int i);
      int unsigned rm, cand, nxt;
      rm   = cfg_range[i];
      cand = m_lfsr[i] & ((32'd1 << kbits(rm)) - 32'd1);
      if (in_load[i]) nxt = (in_seed[i] == 0) ? 1 : in_seed[i];
      else            nxt = lstep(m_lfsr[i], 32'hB400, 16, 1);
      if (m_draw[i]) begin
         if (cand < rm) begin
            m_num[i] = cand + 1; m_fb[i] = 0; m_valid[i] = 1; m_draw[i] = 0; m_hold[i] = 1;
         end else if (m_tries[i] + 1 == cfg_tries[i]) begin
            m_num[i] = (cand % rm) + 1; m_fb[i] = 1; m_valid[i] = 1; m_draw[i] = 0; m_hold[i] = 1;
         end else begin
            m_tries[i]++;
         end
      end else if (m_hold[i]) begin
         if (in_rdy[i]) begin
            m_valid[i] = 0; m_hold[i] = 0;
            if (in_req[i]) begin m_draw[i] = 1; m_tries[i] = 0; end
         end
      end else if (in_req[i]) begin
         m_draw[i] = 1; m_tries[i] = 0;
      end
      m_lfsr[i] = nxt;
   endtask

   task automatic model_compare(input int i);
      check($sformatf("rnd%0d_valid", i), o_valid[i], m_valid[i]);
      check($sformatf("rnd%0d_lfsr", i), o_lfsr[i], m_lfsr[i]);
      if (m_valid[i]) begin
         check($sformatf("rnd%0d_num", i), o_num[i], m_num[i]);
         check($sformatf("rnd%0d_fallback", i), o_fb[i], m_fb[i]);
         check($sformatf("rnd%0d_range", i), (o_num[i] >= 1 && o_num[i] <= cfg_range[i]), 1);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int unsigned s, cap_num;
      bit cap_fb;
      bit seen [16];

      if4.seed_load = 1'b0; if4.seed_in = '0; if4.rand_req = 1'b0; if4.rand_ready = 1'b0;
      reset = 1'b1;
      clear_inputs();
      tick();
      tick();

      // reset state
      for (int i = 0; i < NI; i++) begin
         check("reset_valid", o_valid[i], 0);
         check("reset_num", o_num[i], 0);
         check("reset_fallback", o_fb[i], 0);
         check("reset_lfsr", o_lfsr[i], 1);
      end
      check("reset_lfsr4", if4.lfsr_state, 1);
      reset = 1'b0;

      // 4-bit LFSR walks all 15 nonzero states once, then wraps to 1
      s = 1;
      for (int k = 0; k < 16; k++) seen[k] = 1'b0;
      seen[1] = 1'b1;
      for (int c = 1; c <= 15; c++) begin
         tick();
         s = lstep(s, 32'hC, 4, 1);
         check("t1_lfsr", if4.lfsr_state, s);
         if (c < 15) begin
            check("t1_unique", (if4.lfsr_state != 0 && !seen[if4.lfsr_state]), 1);
            seen[if4.lfsr_state] = 1'b1;
         end else begin
            check("t1_wrap", if4.lfsr_state, 1);
         end
      end

      // table: range 5, single try (forced fallback, hold, seed loads)
      vt[0]  = '{1'b1, 32'h7, 1'b1, 1'b0, 1'b0, 0, 1'b0, 32'h7};
      vt[1]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 3, 1'b1, 32'hE};
      vt[2]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 3, 1'b1, 32'h1C};
      vt[3]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 32'h38};
      vt[4]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 32'h70};
      vt[5]  = '{1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h1};
      vt[6]  = '{1'b1, 32'h1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 32'h1};
      vt[7]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2, 1'b0, 32'h2};
      vt[8]  = '{1'b1, 32'h6, 1'b0, 1'b0, 1'b1, 2, 1'b0, 32'h6};
      vt[9]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 32'hC};
      vt[10] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5, 1'b0, 32'h18};
      vt[11] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5, 1'b0, 32'h30};
      for (int v = 0; v < 12; v++) begin
         in_load[1] = vt[v].load; in_seed[1] = vt[v].sin;
         in_req[1] = vt[v].req;   in_rdy[1] = vt[v].rdy;
         drive_bus();
         tick();
         check($sformatf("tbl%0d_valid", v), o_valid[1], vt[v].valid);
         check($sformatf("tbl%0d_lfsr", v), o_lfsr[1], vt[v].lfsr);
         if (vt[v].valid) begin
            check($sformatf("tbl%0d_num", v), o_num[1], vt[v].num);
            check($sformatf("tbl%0d_fallback", v), o_fb[1], vt[v].fb);
         end
      end

      // throughput, latency and distribution with req and ready held high
      do_reset();
      in_req[0] = 1'b1; in_rdy[0] = 1'b1; drive_bus();
      wait_valid(0, 20, n);
      check("t2_latency", n, 2);
      for (int k = 0; k < 5; k++) cnt[k] = 0;
      for (int d = 0; d < 4000; d++) begin
         check("t2_fallback", o_fb[0], 0);
         check("t2_range", (o_num[0] >= 1 && o_num[0] <= 4), 1);
         if (o_num[0] >= 1 && o_num[0] <= 4) cnt[o_num[0]]++;
         if (d < 3999) begin
            tick();
            check("t2_gap", o_valid[0], 0);
            tick();
            check("t2_rate", o_valid[0], 1);
         end
      end
      for (int k = 1; k <= 4; k++) check($sformatf("t2_dist%0d", k), (cnt[k] >= 900 && cnt[k] <= 1100), 1);

      // backpressure
      do_reset();
      in_req[0] = 1'b1; drive_bus();
      wait_valid(0, 20, n);
      check("t4_latency", n, 2);
      cap_num = o_num[0]; cap_fb = o_fb[0];
      in_req[0] = 1'b0; drive_bus();
      for (int c = 0; c < 10; c++) begin
         tick();
         check("t4_hold_valid", o_valid[0], 1);
         check("t4_hold_num", o_num[0], cap_num);
         check("t4_hold_fallback", o_fb[0], cap_fb);
      end
      in_rdy[0] = 1'b1; drive_bus();
      tick();
      in_rdy[0] = 1'b0; drive_bus();
      check("t4_release", o_valid[0], 0);
      tick();
      check("t4_idle", o_valid[0], 0);
      in_req[0] = 1'b1; drive_bus();
      wait_valid(0, 20, n);
      in_rdy[0] = 1'b1; drive_bus();
      tick();
      in_rdy[0] = 1'b0; drive_bus();
      check("t4_b2b_gap", o_valid[0], 0);
      tick();
      check("t4_b2b_valid", o_valid[0], 1);
      in_req[0] = 1'b0; drive_bus();

      // zero seed substitution and reproducibility from a fixed seed
      do_reset();
      in_load[0] = 1'b1; in_seed[0] = 0; drive_bus();
      tick();
      check("t5_zero_seed", o_lfsr[0], 1);
      for (int r = 0; r < 2; r++) begin
         in_load[0] = 1'b1; in_seed[0] = 32'hACE1; in_req[0] = 1'b0; in_rdy[0] = 1'b0; drive_bus();
         tick();
         check("t5_loaded", o_lfsr[0], 32'hACE1);
         in_load[0] = 1'b0; in_req[0] = 1'b1; in_rdy[0] = 1'b1; drive_bus();
         for (int k = 0; k < 8; k++) begin
            wait_valid(0, 10, n);
            vals[r][k] = o_num[0];
            if (k < 7) tick();
         end
         in_req[0] = 1'b0; drive_bus();
         tick();
         in_rdy[0] = 1'b0; drive_bus();
         tick();
      end
      s = 32'hACE1;
      for (int k = 0; k < 8; k++) begin
         s = lstep(s, 32'hB400, 16, 1);
         check("t5_value", vals[0][k], (s & 3) + 1);
         check("t5_repeat", vals[1][k], vals[0][k]);
         s = lstep(s, 32'hB400, 16, 1);
      end

      // reset while holding a value
      do_reset();
      in_req[0] = 1'b1; drive_bus();
      wait_valid(0, 20, n);
      reset = 1'b1; in_req[0] = 1'b0; drive_bus();
      tick();
      check("t6_valid", o_valid[0], 0);
      check("t6_num", o_num[0], 0);
      check("t6_lfsr", o_lfsr[0], 1);
      reset = 1'b0; in_req[0] = 1'b1; drive_bus();
      wait_valid(0, 20, n);
      check("t6_latency", n, 2);
      check("t6_value", o_num[0], 3);
      check("t6_fallback", o_fb[0], 0);

      // randomized traffic against the reference model
      do_reset();
      for (int i = 0; i < NI; i++) model_reset(i);
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NI; i++) begin
            in_load[i] = ($urandom_range(15) == 0);
            in_seed[i] = ($urandom_range(7) == 0) ? 0 : $urandom_range(65535);
            in_req[i]  = 1'($urandom_range(1));
            in_rdy[i]  = 1'($urandom_range(1));
         end
         drive_bus();
         tick();
         for (int i = 0; i < NI; i++) begin
            model_step(i);
            model_compare(i);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
